// File: rtl/ldl_sfifo_v1.sv
// ldl_sfifo_v1: single-clock synchronous FIFO, 2^AW x DW storage.
// AHEAD=1 gives first-word-fall-through output, AHEAD=0 gives a registered
// read with one cycle of latency. Flags and counts derive from the pointers.
module ldl_sfifo_v1 #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int AHEAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] din,
    output logic          empty,
    output logic          full,
    output logic [DW-1:0] dout,
    output logic [AW:0]   wcnt,
    output logic [AW:0]   rcnt
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty stay distinct
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   occ;
    logic          wr_ok;
    logic          rd_ok;
    logic [DW-1:0] mem [DEPTH];

    // Occupancy is a modular difference; wrap of the extra bit cancels out
    function automatic logic [AW:0] occupancy(input logic [AW:0] w,
                                              input logic [AW:0] r);
        return w - r;
    endfunction

    // Counts and flags depend only on the registered pointers
    always_comb begin
        occ   = occupancy(wptr, rptr);
        rcnt  = occ;
        wcnt  = DEPTH_CNT - occ;
        empty = (rcnt == '0);
        full  = (wcnt == '0);
    end

    // Accesses are qualified with flags sampled before the edge
    assign wr_ok = we && !full;
    assign rd_ok = re && !empty;

    // Pointer advance on each accepted access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // Storage array, cleared on reset so the look-ahead output is defined
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    generate
        if (AHEAD != 0) begin : g_ahead
            // Head word presented combinationally; qualify with !empty
            assign dout = mem[rptr[AW-1:0]];
        end else begin : g_reg
            logic [DW-1:0] dout_r;
            // Head word captured on an accepted read, held otherwise
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_r <= '0;
                end else if (rd_ok) begin
                    dout_r <= mem[rptr[AW-1:0]];
                end
            end
            assign dout = dout_r;
        end
    endgenerate

endmodule

// File: tb/tb_ldl_sfifo_v1.sv
// Bench for ldl_sfifo_v1: drives one look-ahead and one registered-read
// instance with identical stimulus and compares both against a queue model.
module tb_ldl_sfifo_v1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we  = 1'b0;
    logic       re  = 1'b0;
    logic [7:0] din = 8'h00;

    logic       empty_a, full_a, empty_r, full_r;
    logic [7:0] dout_a, dout_r;
    logic [4:0] wcnt_a, rcnt_a, wcnt_r, rcnt_r;

    int total = 0;
    int bad   = 0;

    // Reference: queue of stored words, image of last-written values per slot
    logic [7:0] q[$];
    logic [7:0] smem [16];
    int         wn;
    int         rn;
    logic [7:0] dreg;

    ldl_sfifo_v1 #(.DW(8), .AW(4), .AHEAD(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din),
        .empty(empty_a), .full(full_a), .dout(dout_a),
        .wcnt(wcnt_a), .rcnt(rcnt_a)
    );

    ldl_sfifo_v1 #(.DW(8), .AW(4), .AHEAD(0)) u_r (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din),
        .empty(empty_r), .full(full_r), .dout(dout_r),
        .wcnt(wcnt_r), .rcnt(rcnt_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 16; i++) smem[i] = 8'h00;
        wn   = 0;
        rn   = 0;
        dreg = 8'h00;
    endtask

    task automatic check_all(input string tag);
        int         n;
        logic [7:0] head;
        n    = q.size();
        head = (n != 0) ? q[0] : smem[rn % 16];
        chk({tag, ".rcnt_a"},  rcnt_a,  n);
        chk({tag, ".wcnt_a"},  wcnt_a,  16 - n);
        chk({tag, ".empty_a"}, empty_a, (n == 0));
        chk({tag, ".full_a"},  full_a,  (n == 16));
        chk({tag, ".dout_a"},  dout_a,  head);
        chk({tag, ".rcnt_r"},  rcnt_r,  n);
        chk({tag, ".wcnt_r"},  wcnt_r,  16 - n);
        chk({tag, ".empty_r"}, empty_r, (n == 0));
        chk({tag, ".full_r"},  full_r,  (n == 16));
        chk({tag, ".dout_r"},  dout_r,  dreg);
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
        bit was_full;
        bit was_empty;
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (r && !was_empty) begin
            dreg = q.pop_front();
            rn++;
        end
        if (w && !was_full) begin
            q.push_back(d);
            smem[wn % 16] = d;
            wn++;
        end
        #1;
        check_all(tag);
    endtask

    bit pat1 [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit pat2 [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 rst = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(8'ha1 + i), "fill");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, "drain");

        for (int i = 0; i < 13; i++) step(pat1[i], 1'b1, 8'($urandom), "gap1");
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 8'h00, "gap1_tail");
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 5; i++) step(pat2[i], 1'b1, 8'($urandom), "gap2");
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 8'h00, "gap2_tail");

        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'($urandom), "mid_fill");
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 8'($urandom), "mid_both");
        while (q.size() < 16)        step(1'b1, 1'b0, 8'($urandom), "top_fill");
        step(1'b1, 1'b1, 8'hee, "full_both");
        step(1'b0, 1'b0, 8'h00, "full_idle");
        while (q.size() > 0)         step(1'b0, 1'b1, 8'h00, "bottom_drain");
        step(1'b1, 1'b1, 8'h3c, "empty_both");
        step(1'b0, 1'b1, 8'h00, "empty_pop");

        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 8'($urandom), "pre_rst");
        #1 rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        we = 1'b0;
        re = 1'b0;
        #2 rst = 1'b1;
        step(1'b1, 1'b0, 8'h5c, "post_rst_wr");
        step(1'b0, 1'b1, 8'h00, "post_rst_rd");

        for (int i = 0; i < 200; i++)
            step(($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom), "rnd_fillbias");
        for (int i = 0; i < 200; i++)
            step(($urandom % 2) == 0, ($urandom % 2) == 0, 8'($urandom), "rnd_even");
        for (int i = 0; i < 200; i++)
            step(($urandom % 3) == 0, ($urandom % 4) != 0, 8'($urandom), "rnd_drainbias");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldl_sfifo_v1.md
# ldl_sfifo_v1

Single-clock, parameterized synchronous FIFO with selectable read mode: first-word-fall-through (look-ahead) or registered read. It provides full/empty flags and free-space/available-word counts. It buffers data between a producer and a consumer in the same clock domain, as a generic library primitive.

## Interface
Parameters:
- DW, default 8: data width in bits.
- AW, default 4: address width; depth = 2^AW words (16 by default).
- AHEAD, default 1: 1 = first-word-fall-through (look-ahead) read; 0 = registered read with one-cycle latency.

Ports:
- clk, input, 1: the only clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- we, input, 1: write enable; accepted only when full=0.
- re, input, 1: read enable; accepted only when empty=0.
- din, input, DW: write data, sampled on a rising edge when a write is accepted.
- empty, output, 1: no word available to read.
- full, output, 1: no free location.
- dout, output, DW: read data.
- wcnt, output, AW+1: free locations, range 0..2^AW.
- rcnt, output, AW+1: words available to read, range 0..2^AW.

## Operation
- Storage is a 2^AW × DW array with AW+1-bit write and read pointers.
  - The MSB is the wrap bit.
  - Pointers increment by 1 per accepted access and wrap naturally.
- Occupancy = wptr − rptr, computed modulo 2^(AW+1).
- rcnt = occupancy; wcnt = 2^AW − occupancy; both are AW+1 bits wide and unsigned.
- empty = (rcnt==0); full = (wcnt==0). Both are functions of registered pointers only.
- Accepted write: `we && !full`. Stores din at wptr[AW-1:0], then wptr+1.
- Accepted read: `re && !empty`. Pops the head word, then rptr+1.
- Write while full is ignored: no storage, no pointer change, no error flag.
- Read while empty is ignored; dout is unchanged.
- Simultaneous we and re:
  - Not full and not empty: both are performed and occupancy is unchanged.
  - Full: only the read is performed; the write is dropped because full is evaluated before the edge.
  - Empty: only the write is performed.
- AHEAD=1: dout = mem[rptr[AW-1:0]] combinationally.
  - While empty=0, dout is the head word.
  - While empty=1, dout is the content of the next location to be written; consumers must qualify it with !empty.
- AHEAD=0: dout is a register loaded with mem[rptr] on an accepted read; it holds its value otherwise.
- Memory contents are cleared to 0 on reset.

## Timing
- Reset (rst=0, asynchronous) sets: pointers = 0, memory = 0, dout = 0, empty = 1, full = 0, rcnt = 0, wcnt = 2^AW.
- Exit from reset is synchronous to the next rising edge; no operation is lost on the first edge after release.
- Write to empty FIFO at edge k:
  - empty falls, rcnt = 1 and wcnt = 2^AW−1 right after edge k.
  - AHEAD=1: dout = written word right after edge k.
- AHEAD=1 read: the current dout is consumed at the edge; the next word appears right after that edge.
- AHEAD=0 read: re accepted at edge k puts the head word on dout after edge k, one cycle of latency.
- Full rises right after the edge accepting the 2^AW-th outstanding word.
- A read at edge k on a full FIFO lowers full after edge k.
- Flags and counts have zero cycles of lag relative to the pointers; there is no almost-full or almost-empty output.
- Pointer wrap: after 2^AW accesses, wptr/rptr MSB toggles, and full/empty remain correct across any number of wraps.

## Test plan
- Reset then idle → empty=1, full=0, rcnt=0, wcnt=16, dout=0.
- Set we=1 for 20 cycles with din=0xa1..0xb4 → full after the 16th write, wcnt=0, rcnt=16; 0xb1..0xb4 are dropped.
- Then set re=1 for 20 cycles:
  - AHEAD=1: dout reads 0xa1..0xb0 in order, then empty=1 with rcnt=0.
  - AHEAD=0: same sequence lagging one cycle.
  - Reads while empty leave dout unchanged.
- With re held at 1, write patterns d,gap,d×11 and d,d,gap,d,d → each word is returned exactly once, in order; rcnt never exceeds 1–2.
- Simultaneous we and re:
  - Non-empty, not full: rcnt is constant and order is preserved.
  - At full: write dropped, rcnt=15.
  - At empty: only the write is taken, rcnt=1.
- Assert rst low mid-stream with 8 words stored → immediately empty=1, rcnt=0, wcnt=16, dout=0; the next write/read pair returns the new data.
- Run more than 3×16 writes/reads → no flag errors across pointer wrap; data order is intact.
